// File: rtl/sram_bus_responder.sv
// Serves one 32-bit word per core request from a 16-bit asynchronous SRAM, as a low half then a
// high half, with a turnaround cycle between them and a one-cycle quiet gap after completion.
module sram_bus_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [22:0] sdram_addr,
  input  logic        sdram_read,
  input  logic        sdram_write,
  input  logic [31:0] sdram_writedata,
  output logic [31:0] sdram_readdata,
  output logic        sdram_finished,
  output logic        bus_error,
  inout  wire  [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_TURN = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [18:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          is_wr_q;
  logic          oor_q;
  logic          err_pend_q;
  logic [15:0]   lo_q;
  logic [31:0]   readdata_q;
  logic          finished_q;
  logic          err_q;
  logic [19:0]   sram_addr_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          ce_n_q;
  logic          bs_n_q;
  logic [15:0]   dq_out_q;

  // DQ is only ever driven while a write strobe is active, so the bus floats otherwise.
  assign SRAM_DQ        = we_n_q ? 16'hzzzz : dq_out_q;
  assign SRAM_ADDR      = sram_addr_q;
  assign SRAM_OE_N      = oe_n_q;
  assign SRAM_WE_N      = we_n_q;
  assign SRAM_CE_N      = ce_n_q;
  assign SRAM_UB_N      = bs_n_q;
  assign SRAM_LB_N      = bs_n_q;
  assign sdram_readdata = readdata_q;
  assign sdram_finished = finished_q;
  assign bus_error      = err_q;
  assign dbg_state_o    = state_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      oor_q       <= 1'b0;
      err_pend_q  <= 1'b0;
      lo_q        <= '0;
      readdata_q  <= '0;
      finished_q  <= 1'b0;
      err_q       <= 1'b0;
      sram_addr_q <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      bs_n_q      <= 1'b1;
      dq_out_q    <= '0;
    end else begin
      finished_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sdram_read || sdram_write) begin
            // Write wins when both are requested; either fault is flagged at completion.
            addr_q      <= sdram_addr[18:0];
            wdata_q     <= sdram_writedata;
            is_wr_q     <= sdram_write;
            oor_q       <= (sdram_addr[22:19] != 4'd0);
            err_pend_q  <= (sdram_addr[22:19] != 4'd0) || (sdram_read && sdram_write);
            cnt_q       <= '0;
            sram_addr_q <= {sdram_addr[18:0], 1'b0};
            dq_out_q    <= sdram_writedata[15:0];
            state_q     <= S_LO;
            if (sdram_addr[22:19] == 4'd0) begin
              ce_n_q <= 1'b0;
              bs_n_q <= 1'b0;
              we_n_q <= ~sdram_write;
              oe_n_q <= sdram_write;
            end
          end
        end
        S_LO: begin
          if (cnt_q == CNT_LAST) begin
            lo_q    <= SRAM_DQ;
            cnt_q   <= '0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            bs_n_q  <= 1'b1;
            state_q <= S_TURN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_TURN: begin
          sram_addr_q <= {addr_q, 1'b1};
          dq_out_q    <= wdata_q[31:16];
          state_q     <= S_HI;
          if (!oor_q) begin
            bs_n_q <= 1'b0;
            we_n_q <= ~is_wr_q;
            oe_n_q <= is_wr_q;
          end
        end
        S_HI: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q      <= '0;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            bs_n_q     <= 1'b1;
            finished_q <= 1'b1;
            err_q      <= err_pend_q;
            if (!is_wr_q) begin
              readdata_q <= oor_q ? 32'd0 : {SRAM_DQ, lo_q};
            end
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE:  state_q <= S_GAP;
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: behavioural SRAM models behind a WAIT_CYCLES=1 and a WAIT_CYCLES=3
// instance, a vector table of bus transactions, and hand-written reset and slow-timing sequences.
module tb_sram_bus_responder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WAIT_CYCLES = 1 instance
  logic [22:0] addr;
  logic        rd, wr;
  logic [31:0] wdata, rdata;
  logic        fin, err;
  wire  [15:0] dq;
  logic [19:0] saddr;
  logic        oe_n, we_n, ce_n, ub_n, lb_n;
  logic [2:0]  dbg;
  logic [15:0] mem [0:255];

  sram_bus_responder #(.WAIT_CYCLES(1)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .sdram_addr(addr), .sdram_read(rd), .sdram_write(wr),
    .sdram_writedata(wdata), .sdram_readdata(rdata), .sdram_finished(fin), .bus_error(err),
    .SRAM_DQ(dq), .SRAM_ADDR(saddr), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .dbg_state_o(dbg)
  );

  assign dq = (!ce_n && !oe_n && we_n) ? mem[saddr[7:0]] : 16'hzzzz;
  always @(posedge clk) if (!ce_n && !we_n && !ub_n && !lb_n) mem[saddr[7:0]] <= dq;

  // WAIT_CYCLES = 3 instance
  logic [22:0] addr3;
  logic        rd3, wr3;
  logic [31:0] wdata3, rdata3;
  logic        fin3, err3;
  wire  [15:0] dq3;
  logic [19:0] saddr3;
  logic        oe3_n, we3_n, ce3_n, ub3_n, lb3_n;
  logic [2:0]  dbg3;
  logic [15:0] mem3 [0:255];

  sram_bus_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst_n), .sdram_addr(addr3), .sdram_read(rd3), .sdram_write(wr3),
    .sdram_writedata(wdata3), .sdram_readdata(rdata3), .sdram_finished(fin3), .bus_error(err3),
    .SRAM_DQ(dq3), .SRAM_ADDR(saddr3), .SRAM_OE_N(oe3_n), .SRAM_WE_N(we3_n), .SRAM_CE_N(ce3_n),
    .SRAM_UB_N(ub3_n), .SRAM_LB_N(lb3_n), .dbg_state_o(dbg3)
  );

  assign dq3 = (!ce3_n && !oe3_n && we3_n) ? mem3[saddr3[7:0]] : 16'hzzzz;
  always @(posedge clk) if (!ce3_n && !we3_n && !ub3_n && !lb3_n) mem3[saddr3[7:0]] <= dq3;

  // Free-running strobe/pulse counters, sampled mid-cycle; sequences take differences.
  int ce_low_cnt, we_low_cnt, fin_cnt, oe3_low_cnt, fin3_cnt;
  initial begin
    ce_low_cnt = 0; we_low_cnt = 0; fin_cnt = 0; oe3_low_cnt = 0; fin3_cnt = 0;
  end
  always @(negedge clk) begin
    if (!ce_n) ce_low_cnt++;
    if (!we_n) we_low_cnt++;
    if (fin)   fin_cnt++;
    if (!oe3_n) oe3_low_cnt++;
    if (fin3)  fin3_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        mem_chk;
    logic [7:0]  mem_idx;
    logic [31:0] exp_mem;
  } vec_t;

  // One request held until finished and through the gap; inputs scrambled after acceptance.
  task automatic run_txn(input vec_t v, input int id);
    int lat, ce0, we0, f0, exp_ce, exp_we;
    logic got_err;
    logic [31:0] got_rd;
    logic oor;
    lat = 0; got_err = 1'b0; got_rd = 32'd0;
    oor = (v.addr[22:19] != 4'd0);
    exp_ce = oor ? 0 : 3;
    exp_we = (v.wr && !oor) ? 2 : 0;
    @(posedge clk); #1;
    rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    ce0 = ce_low_cnt; we0 = we_low_cnt; f0 = fin_cnt;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        addr  = 23'($urandom);
        wdata = $urandom;
      end
      if (fin) begin
        lat = i; got_err = err; got_rd = rdata;
        break;
      end
    end
    chk($sformatf("v%0d latency", id), lat, 4);
    chk($sformatf("v%0d bus_error", id), {31'd0, got_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d readdata", id), got_rd, v.exp_rdata);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk($sformatf("v%0d finished_pulses", id), fin_cnt - f0, 1);
    chk($sformatf("v%0d ce_low_cycles", id), ce_low_cnt - ce0, exp_ce);
    chk($sformatf("v%0d we_low_cycles", id), we_low_cnt - we0, exp_we);
    if (v.mem_chk)
      chk($sformatf("v%0d sram_word", id), {mem[int'(v.mem_idx) + 1], mem[v.mem_idx]}, v.exp_mem);
  endtask

  vec_t vecs [11];
  vec_t tail;
  int   lat3, oe0, f30, f0;
  logic [31:0] rd3_got;

  initial begin
    n_checks = 0; n_errors = 0;
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd3 = 0; wr3 = 0; addr3 = 0; wdata3 = 0;
    //        rd wr addr         wdata          exp_rdata      err mchk idx    exp_mem
    vecs[0]  = '{0, 1, 23'h000000, 32'h0F0FF0F0, 32'h00000000, 0, 1, 8'h00, 32'h0F0FF0F0};
    vecs[1]  = '{0, 1, 23'h000005, 32'hDEADBEEF, 32'h00000000, 0, 1, 8'h0A, 32'hDEADBEEF};
    vecs[2]  = '{1, 0, 23'h000005, 32'h00000000, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0};
    vecs[3]  = '{0, 1, 23'h080000, 32'hCAFEF00D, 32'hDEADBEEF, 1, 1, 8'h00, 32'h0F0FF0F0};
    vecs[4]  = '{1, 0, 23'h080000, 32'h00000000, 32'h00000000, 1, 0, 8'h00, 32'h0};
    vecs[5]  = '{1, 0, 23'h000000, 32'h00000000, 32'h0F0FF0F0, 0, 0, 8'h00, 32'h0};
    vecs[6]  = '{1, 1, 23'h000003, 32'hA5A55A5A, 32'h0F0FF0F0, 1, 1, 8'h06, 32'hA5A55A5A};
    vecs[7]  = '{1, 0, 23'h000003, 32'h00000000, 32'hA5A55A5A, 0, 0, 8'h00, 32'h0};
    vecs[8]  = '{0, 1, 23'h07FFFF, 32'h01020304, 32'hA5A55A5A, 0, 1, 8'hFE, 32'h01020304};
    vecs[9]  = '{1, 0, 23'h07FFFF, 32'h00000000, 32'h01020304, 0, 0, 8'h00, 32'h0};
    vecs[10] = '{0, 1, 23'h400000, 32'h11111111, 32'h01020304, 1, 1, 8'h00, 32'h0F0FF0F0};

    // Reset held three cycles.
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset strobes", {27'd0, oe_n, we_n, ce_n, ub_n, lb_n}, 32'h1F);
    chk("reset sram_addr", {12'd0, saddr}, 32'd0);
    chk("reset finished/err", {30'd0, fin, err}, 32'd0);
    chk("reset readdata", rdata, 32'd0);
    chk("reset state", {29'd0, dbg}, 32'd0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

    // Slow SRAM: write then read word 0, read phases last three cycles each.
    @(posedge clk); #1;
    wr3 = 1'b1; addr3 = 23'h000000; wdata3 = 32'h77885566;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (fin3) break;
    end
    @(posedge clk); #1; wr3 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rd3 = 1'b1; oe0 = oe3_low_cnt; f30 = fin3_cnt; lat3 = 0; rd3_got = 32'd0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (fin3) begin lat3 = i; rd3_got = rdata3; break; end
    end
    @(posedge clk); #1; rd3 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("w3 latency", lat3, 8);
    chk("w3 readdata", rd3_got, 32'h77885566);
    chk("w3 oe_low_cycles", oe3_low_cnt - oe0, 6);
    chk("w3 finished_pulses", fin3_cnt - f30, 1);

    // Reset during the high half of a write.
    @(posedge clk); #1;
    wr = 1'b1; addr = 23'h000009; wdata = 32'h13572468;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst in high half", {29'd0, dbg}, 32'd3);
    rst_n = 1'b0; f0 = fin_cnt;
    @(posedge clk); #1;
    wr = 1'b0;
    chk("midrst we_n/ce_n", {30'd0, we_n, ce_n}, 32'h3);
    chk("midrst state", {29'd0, dbg}, 32'd0);
    chk("midrst readdata", rdata, 32'd0);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst no finished", fin_cnt - f0, 0);
    tail = '{1, 0, 23'h000005, 32'h0, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0};
    run_txn(tail, 99);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
